// File: rtl/frame_pkg.sv
// Shared types and defaults for the framebuffer write path.
package frame_pkg;

  localparam int unsigned H_RES_DEF   = 640;
  localparam int unsigned V_RES_DEF   = 480;
  localparam int unsigned FRAME_WORDS = H_RES_DEF * V_RES_DEF;
  localparam int unsigned ADDR_W      = 26;
  localparam int unsigned RGB_W       = 24;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [RGB_W-1:0]  rgb_t;

  // One queued pixel: final word address plus colour.
  typedef struct packed {
    addr_t addr;
    rgb_t  rgb;
  } pix_word_t;

  typedef enum logic [1:0] {
    IDLE,
    PIX_REQ,
    CLEAR_REQ,
    CLEAR_NEXT
  } fw_state_t;

  // A framebuffer word carries the colour in its low 24 bits.
  function automatic logic [31:0] pack_word(input rgb_t rgb);
    return {8'h00, rgb};
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO holding pixels that already carry final addresses.
module pixel_fifo
  import frame_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      Clk,
  input  logic      Reset,
  input  logic      i_push,
  input  pix_word_t i_data,
  input  logic      i_pop,
  output pix_word_t o_data,
  output logic      o_full,
  output logic      o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  pix_word_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so push+pop while full is legal.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage; contents need no reset because occupancy gates reads.
  always_ff @(posedge Clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/frame_writer.sv
// Writes drawing-engine pixels and full-frame clears into the SDRAM
// framebuffer through the shared sdram_master write port.
module frame_writer
  import frame_pkg::*;
#(
  parameter int unsigned H_RES      = H_RES_DEF,
  parameter int unsigned V_RES      = V_RES_DEF,
  parameter addr_t       BASE_ADDR  = 26'h0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic [23:0] pix_rgb,
  input  logic        clear_start,
  input  logic [23:0] clear_rgb,
  output logic        clear_done,
  output logic        busy,
  input  logic        mem_grant,
  output logic        write_req,
  output logic [25:0] address,
  output logic [31:0] write_data,
  input  logic        ready
);

  localparam addr_t LAST_WORD = addr_t'(H_RES * V_RES - 1);
  localparam addr_t H_RES_A   = addr_t'(H_RES);

  fw_state_t   r_state;
  logic        r_write_req;
  addr_t       r_address;
  logic [31:0] r_write_data;
  logic        r_clear_done;
  logic        r_clear_active;
  rgb_t        r_clear_rgb;
  addr_t       r_clear_cnt;

  logic        w_in_range;
  logic        w_push;
  logic        w_pop;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  addr_t       w_pix_addr;
  pix_word_t   w_push_word;
  pix_word_t   w_head;

  // Off-screen pixels still complete their handshake but are dropped here.
  assign w_in_range  = (32'(pix_x) < H_RES) && (32'(pix_y) < V_RES);
  assign w_pix_addr  = BASE_ADDR + addr_t'(pix_y) * H_RES_A + addr_t'(pix_x);
  assign w_push_word = {w_pix_addr, pix_rgb};
  assign pix_ready   = !w_fifo_full;
  assign w_push      = pix_valid && pix_ready && w_in_range;
  // Pending clear outranks queued pixels, so only pop when no clear is waiting.
  assign w_pop       = (r_state == IDLE) && !r_clear_active && !w_fifo_empty && mem_grant;

  assign busy       = !w_fifo_empty || r_clear_active || r_write_req;
  assign write_req  = r_write_req;
  assign address    = r_address;
  assign write_data = r_write_data;
  assign clear_done = r_clear_done;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_push  (w_push),
    .i_data  (w_push_word),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Write-port FSM plus clear bookkeeping; all master-facing outputs registered.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state        <= IDLE;
      r_write_req    <= 1'b0;
      r_address      <= '0;
      r_write_data   <= '0;
      r_clear_done   <= 1'b0;
      r_clear_active <= 1'b0;
      r_clear_cnt    <= '0;
    end else begin
      r_clear_done <= 1'b0;

      // A new clear is only taken when none is running.
      if (clear_start && !r_clear_active) begin
        r_clear_active <= 1'b1;
        r_clear_rgb    <= clear_rgb;
        r_clear_cnt    <= '0;
      end

      case (r_state)
        IDLE: begin
          if (r_clear_active && mem_grant) begin
            r_write_req  <= 1'b1;
            r_address    <= BASE_ADDR + r_clear_cnt;
            r_write_data <= pack_word(r_clear_rgb);
            r_state      <= CLEAR_REQ;
          end else if (w_pop) begin
            r_write_req  <= 1'b1;
            r_address    <= w_head.addr;
            r_write_data <= pack_word(w_head.rgb);
            r_state      <= PIX_REQ;
          end
        end
        PIX_REQ: begin
          if (ready) begin
            r_write_req <= 1'b0;
            r_state     <= IDLE;
          end
        end
        CLEAR_REQ: begin
          if (ready) begin
            r_write_req <= 1'b0;
            if (r_clear_cnt == LAST_WORD) begin
              r_clear_done   <= 1'b1;
              r_clear_active <= 1'b0;
              r_state        <= IDLE;
            end else begin
              r_state <= CLEAR_NEXT;
            end
          end
        end
        CLEAR_NEXT: begin
          r_clear_cnt <= r_clear_cnt + 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// Bench for frame_writer: a 4x2 instance for clears/FIFO behaviour and a
// default 640x480 instance for address arithmetic and range discards.
`timescale 1ns/1ps
module tb_frame_writer;

  localparam logic [25:0] SB = 26'h1000;
  localparam int SH = 4;
  localparam int SV = 2;
  localparam int BH = 640;
  localparam int BV = 480;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  logic        s_pv, s_pr, s_cs, s_cd, s_busy, s_grant, s_wreq, s_rdy;
  logic [9:0]  s_px, s_py;
  logic [23:0] s_prgb, s_crgb;
  logic [25:0] s_addr;
  logic [31:0] s_wdata;

  logic        b_pv, b_pr, b_cs, b_cd, b_busy, b_grant, b_wreq, b_rdy;
  logic [9:0]  b_px, b_py;
  logic [23:0] b_prgb, b_crgb;
  logic [25:0] b_addr;
  logic [31:0] b_wdata;

  frame_writer #(.H_RES(SH), .V_RES(SV), .BASE_ADDR(SB), .FIFO_DEPTH(4)) u_small (
    .Clk(clk), .Reset(rst), .pix_valid(s_pv), .pix_ready(s_pr), .pix_x(s_px), .pix_y(s_py),
    .pix_rgb(s_prgb), .clear_start(s_cs), .clear_rgb(s_crgb), .clear_done(s_cd), .busy(s_busy),
    .mem_grant(s_grant), .write_req(s_wreq), .address(s_addr), .write_data(s_wdata), .ready(s_rdy)
  );

  frame_writer #(.H_RES(BH), .V_RES(BV), .BASE_ADDR(26'h0), .FIFO_DEPTH(4)) u_big (
    .Clk(clk), .Reset(rst), .pix_valid(b_pv), .pix_ready(b_pr), .pix_x(b_px), .pix_y(b_py),
    .pix_rgb(b_prgb), .clear_start(b_cs), .clear_rgb(b_crgb), .clear_done(b_cd), .busy(b_busy),
    .mem_grant(b_grant), .write_req(b_wreq), .address(b_addr), .write_data(b_wdata), .ready(b_rdy)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic        prev_req [2];
  logic [25:0] h_addr [2];
  logic [31:0] h_data [2];
  int          waitc [2];
  int          lat [2];
  int          comp [2];
  int          ndone [2];
  int          done_at [2];
  bit          hold [2];
  bit          noise [2];
  bit          gmode [2];

  logic [57:0] s_log [$];
  logic [57:0] b_log [$];
  logic [57:0] s_exp [$];
  logic [57:0] b_exp [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Per-DUT bus monitor and memory responder, evaluated just after each edge.
  task automatic mon(input int d, input logic req, input logic [25:0] a, input logic [31:0] wd,
                     input logic cd, input logic g_now, input logic r_now,
                     output logic r_next, output logic g_next);
    if (prev_req[d] && r_now) begin
      comp[d]++;
      chk("req_drops_after_ready", 64'(req), 64'd0);
    end
    if (req && !prev_req[d]) begin
      chk("req_rises_with_grant", 64'(g_now), 64'd1);
      if (d == 0) s_log.push_back({a, wd});
      else        b_log.push_back({a, wd});
      h_addr[d] = a;
      h_data[d] = wd;
      waitc[d]  = (lat[d] < 0) ? int'($urandom_range(0, 3)) : lat[d];
    end else if (req) begin
      chk("addr_stable", 64'(a), 64'(h_addr[d]));
      chk("data_stable", 64'(wd), 64'(h_data[d]));
    end
    if (cd) begin
      ndone[d]++;
      done_at[d] = comp[d];
    end
    prev_req[d] = req;
    if (req) begin
      if (!hold[d] && waitc[d] == 0) r_next = 1'b1;
      else begin
        r_next = 1'b0;
        if (waitc[d] > 0) waitc[d]--;
      end
    end else begin
      r_next = noise[d] ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    g_next = gmode[d] ? 1'($urandom_range(0, 1)) : g_now;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    mon(0, s_wreq, s_addr, s_wdata, s_cd, s_grant, s_rdy, s_rdy, s_grant);
    mon(1, b_wreq, b_addr, b_wdata, b_cd, b_grant, b_rdy, b_rdy, b_grant);
  endtask

  // Reference: an on-screen pixel becomes one word at BASE + y*H + x.
  task automatic model_pix(input int d, input logic [9:0] x, input logic [9:0] y, input logic [23:0] rgb);
    int h;
    int v;
    int base;
    logic [25:0] a;
    h    = d ? BH : SH;
    v    = d ? BV : SV;
    base = d ? 0 : int'(SB);
    if (int'(x) < h && int'(y) < v) begin
      a = 26'(base + int'(y) * h + int'(x));
      if (d == 0) s_exp.push_back({a, 8'h00, rgb});
      else        b_exp.push_back({a, 8'h00, rgb});
    end
  endtask

  // Reference: a clear writes every word of the frame in ascending order.
  task automatic model_clear(input int d, input logic [23:0] rgb);
    int words;
    int base;
    words = d ? BH * BV : SH * SV;
    base  = d ? 0 : int'(SB);
    for (int i = 0; i < words; i++) begin
      if (d == 0) s_exp.push_back({26'(base + i), 8'h00, rgb});
      else        b_exp.push_back({26'(base + i), 8'h00, rgb});
    end
  endtask

  task automatic compare_logs(input int d);
    logic [57:0] got [$];
    logic [57:0] want [$];
    if (d == 0) begin
      got = s_log; want = s_exp; s_log.delete(); s_exp.delete();
    end else begin
      got = b_log; want = b_exp; b_log.delete(); b_exp.delete();
    end
    chk("write_count", 64'(got.size()), 64'(want.size()));
    for (int i = 0; i < want.size() && i < got.size(); i++) begin
      chk("write_addr", 64'(got[i][57:32]), 64'(want[i][57:32]));
      chk("write_data", 64'(got[i][31:0]), 64'(want[i][31:0]));
    end
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (n < 2000 && ((d == 0) ? (s_busy || s_wreq) : (b_busy || b_wreq))) begin
      step();
      n++;
    end
    if (n >= 2000) chk("idle_timeout", 64'(n), 64'd0);
  endtask

  task automatic push(input int d, input logic [9:0] x, input logic [9:0] y, input logic [23:0] rgb);
    int n;
    n = 0;
    if (d == 0) begin s_pv = 1'b1; s_px = x; s_py = y; s_prgb = rgb; end
    else        begin b_pv = 1'b1; b_px = x; b_py = y; b_prgb = rgb; end
    while (n < 500 && !((d == 0) ? s_pr : b_pr)) begin
      step();
      n++;
    end
    if (n >= 500) chk("push_timeout", 64'(n), 64'd0);
    model_pix(d, x, y, rgb);
    step();
    if (d == 0) s_pv = 1'b0;
    else        b_pv = 1'b0;
  endtask

  initial begin
    int acc;
    int n;
    logic [23:0] crgb;

    rst = 1'b1;
    s_pv = 0; s_px = '0; s_py = '0; s_prgb = '0; s_cs = 0; s_crgb = '0; s_grant = 1; s_rdy = 0;
    b_pv = 0; b_px = '0; b_py = '0; b_prgb = '0; b_cs = 0; b_crgb = '0; b_grant = 1; b_rdy = 0;
    for (int d = 0; d < 2; d++) begin
      prev_req[d] = 0; h_addr[d] = '0; h_data[d] = '0; waitc[d] = 0; lat[d] = 0;
      comp[d] = 0; ndone[d] = 0; done_at[d] = 0; hold[d] = 0; noise[d] = 0; gmode[d] = 0;
    end
    repeat (3) step();
    rst = 1'b0;

    // Reset state, first cycle after release
    chk("rst_s_write_req", 64'(s_wreq), 64'd0);
    chk("rst_s_address", 64'(s_addr), 64'd0);
    chk("rst_s_write_data", 64'(s_wdata), 64'd0);
    chk("rst_s_clear_done", 64'(s_cd), 64'd0);
    chk("rst_s_busy", 64'(s_busy), 64'd0);
    chk("rst_s_pix_ready", 64'(s_pr), 64'd1);
    chk("rst_b_write_req", 64'(b_wreq), 64'd0);
    chk("rst_b_address", 64'(b_addr), 64'd0);
    chk("rst_b_busy", 64'(b_busy), 64'd0);
    chk("rst_b_pix_ready", 64'(b_pr), 64'd1);

    // Single pixel at full resolution: (3,2) -> 1283
    lat[1] = 3;
    push(1, 10'd3, 10'd2, 24'h123456);
    chk("pix_busy_after_push", 64'(b_busy), 64'd1);
    wait_idle(1);
    compare_logs(1);

    // Off-screen pixels are accepted and discarded
    push(1, 10'd640, 10'd0, 24'hABCDEF);
    chk("offscreen_x_busy", 64'(b_busy), 64'd0);
    push(1, 10'd0, 10'd480, 24'h654321);
    chk("offscreen_y_busy", 64'(b_busy), 64'd0);
    repeat (5) step();
    chk("offscreen_no_req", 64'(b_wreq), 64'd0);
    compare_logs(1);

    // Backpressure: ready withheld, one write in flight plus a full FIFO
    hold[0] = 1; lat[0] = 0; s_grant = 1;
    acc = 0;
    s_pv = 1; s_px = 10'($urandom_range(0, 3)); s_py = 10'($urandom_range(0, 1)); s_prgb = 24'($urandom);
    for (int k = 0; k < 20 && s_pr; k++) begin
      model_pix(0, s_px, s_py, s_prgb);
      step();
      acc++;
      s_px = 10'($urandom_range(0, 3)); s_py = 10'($urandom_range(0, 1)); s_prgb = 24'($urandom);
    end
    s_pv = 0;
    chk("bp_accepted", 64'(acc), 64'd5);
    chk("bp_pix_ready_low", 64'(s_pr), 64'd0);
    chk("bp_busy", 64'(s_busy), 64'd1);
    hold[0] = 0;
    wait_idle(0);
    compare_logs(0);

    // Full clear of a 4x2 frame; a second start mid-clear is ignored
    lat[0] = 1; comp[0] = 0; ndone[0] = 0;
    s_crgb = 24'hFF0000; s_cs = 1;
    step();
    s_cs = 0;
    model_clear(0, 24'hFF0000);
    repeat (4) step();
    s_crgb = 24'h00FF00; s_cs = 1;
    step();
    s_cs = 0;
    wait_idle(0);
    compare_logs(0);
    chk("clear_done_count", 64'(ndone[0]), 64'd1);
    chk("clear_done_at_last", 64'(done_at[0]), 64'd8);

    // Clear plus random pixels, toggling grant, random latency, stray ready
    comp[0] = 0; ndone[0] = 0; gmode[0] = 1; noise[0] = 1; lat[0] = -1;
    crgb = 24'($urandom);
    s_crgb = crgb; s_cs = 1;
    model_clear(0, crgb);
    push(0, 10'($urandom_range(0, 3)), 10'($urandom_range(0, 1)), 24'($urandom));
    s_cs = 0;
    for (int k = 0; k < 10; k++)
      push(0, 10'($urandom_range(0, 5)), 10'($urandom_range(0, 3)), 24'($urandom));
    wait_idle(0);
    gmode[0] = 0; noise[0] = 0; s_grant = 1;
    step();
    compare_logs(0);
    chk("mix_clear_done_count", 64'(ndone[0]), 64'd1);
    chk("mix_clear_first", 64'(done_at[0]), 64'd8);

    // Reset while a clear write is outstanding
    lat[0] = 4; comp[0] = 0; ndone[0] = 0;
    s_crgb = 24'h0000FF; s_cs = 1;
    push(0, 10'd1, 10'd1, 24'h111111);
    s_cs = 0;
    push(0, 10'd2, 10'd0, 24'h222222);
    n = 0;
    while (n < 1000 && !(comp[0] >= 3 && s_wreq)) begin
      step();
      n++;
    end
    if (n >= 1000) chk("midclear_timeout", 64'(n), 64'd0);
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_write_req", 64'(s_wreq), 64'd0);
    chk("mid_rst_busy", 64'(s_busy), 64'd0);
    chk("mid_rst_pix_ready", 64'(s_pr), 64'd1);
    chk("mid_rst_address", 64'(s_addr), 64'd0);
    s_log.delete(); s_exp.delete(); ndone[0] = 0;
    repeat (20) step();
    chk("post_rst_no_done", 64'(ndone[0]), 64'd0);
    chk("post_rst_no_writes", 64'(s_log.size()), 64'd0);

    // Fresh clear restarts at the base address
    lat[0] = 0; comp[0] = 0;
    crgb = 24'($urandom);
    s_crgb = crgb; s_cs = 1;
    step();
    s_cs = 0;
    model_clear(0, crgb);
    wait_idle(0);
    compare_logs(0);
    chk("fresh_clear_done", 64'(ndone[0]), 64'd1);
    chk("fresh_clear_done_at", 64'(done_at[0]), 64'd8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
